mem_access_stage: RTL and testbench

Parameterised memory-access pipeline stage for the five-stage core. It sits between the EX/MEM boundary and the WB stage. It performs byte, half-word and word loads and stores against an internal data memory with configurable access latency, and drives a stall request toward the earlier stages while an access is in flight. It contains the MEM/WB pipeline register and a combinational forwarding result for the hazard unit.

---
 rtl/mem_access_stage.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access stage of the five-stage core, placed between the EX/MEM
// boundary and write-back. It performs byte / half / word (and double when
// DATA_WIDTH is 64) loads and stores against a private data memory whose
// accesses take MEM_LATENCY cycles. While an access is in flight it asks the
// earlier stages to freeze. It also holds the MEM/WB pipeline register and
// drives a combinational forwarding value for the hazard unit.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous, active-high reset
//   mem_read_in      load request
//   mem_write_in     store request (wins over a simultaneous load)
//   wb_enable_in     register write-back request
//   mem_size_in      00 byte, 01 half, 10 word, 11 double (word if 32-bit)
//   mem_signed_in    1 = sign-extend loads, 0 = zero-extend
//   dest_reg_in      destination register index
//   alu_result_in    effective byte address, or plain ALU result
//   store_data_in    store data, right-aligned
//   stall_out        freeze request to IF/ID/EX (combinational)
//   result_out       forwarding value (combinational)
//   mem_read_out     registered load flag
//   wb_enable_out    registered write-back enable
//   alu_result_out   registered ALU result / address
//   dest_reg_out     registered destination register
//   memory_data_out  registered, extended load data
//   misaligned_out   registered one-cycle misalignment fault pulse
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          REG_ADDR_WIDTH = 5,
  parameter int          MEM_WORDS      = 64,
  parameter int          MEM_LATENCY    = 1,
  parameter int unsigned BASE_ADDR      = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_read_in,
  input  logic                      mem_write_in,
  input  logic                      wb_enable_in,
  input  logic [1:0]                mem_size_in,
  input  logic                      mem_signed_in,
  input  logic [REG_ADDR_WIDTH-1:0] dest_reg_in,
  input  logic [DATA_WIDTH-1:0]     alu_result_in,
  input  logic [DATA_WIDTH-1:0]     store_data_in,
  output logic                      stall_out,
  output logic [DATA_WIDTH-1:0]     result_out,
  output logic                      mem_read_out,
  output logic                      wb_enable_out,
  output logic [DATA_WIDTH-1:0]     alu_result_out,
  output logic [REG_ADDR_WIDTH-1:0] dest_reg_out,
  output logic [DATA_WIDTH-1:0]     memory_data_out,
  output logic                      misaligned_out
);

  localparam int BYTES       = DATA_WIDTH / 8;
  localparam int LANE_W      = $clog2(BYTES);
  localparam int IDX_W       = $clog2(MEM_WORDS);
  localparam int CNT_W       = $clog2(MEM_LATENCY) + 1;
  localparam int CNT_START_I = (MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0;

  localparam logic [DATA_WIDTH-1:0] BASE      = DATA_WIDTH'(BASE_ADDR);
  localparam logic [CNT_W-1:0]      CNT_START = CNT_W'(CNT_START_I);

  // Elaboration-time guards on the parameter space this block supports.
  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("mem_access_stage: DATA_WIDTH must be 32 or 64");
  end
  if (MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_depth
    $error("mem_access_stage: MEM_WORDS must be a power of two >= 2");
  end
  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("mem_access_stage: MEM_LATENCY must be >= 1");
  end

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'b00,
    SIZE_HALF   = 2'b01,
    SIZE_WORD   = 2'b10,
    SIZE_DOUBLE = 2'b11
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  size_e                 size_eff;
  logic [3:0]            n_bytes;
  logic [LANE_W-1:0]     align_mask;
  logic [BYTES-1:0]      size_ones;
  logic [DATA_WIDTH-1:0] offset;
  logic [LANE_W-1:0]     lane;
  logic [IDX_W-1:0]      word_idx;
  logic                  access_req;
  logic                  misaligned;
  logic                  access_ok;
  logic                  is_load;

  // NOTE: every signal assigned in an always_comb gets a default on entry, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    size_eff = size_e'(mem_size_in);
    // A 32-bit datapath has no double access; it degrades to a word.
    if (DATA_WIDTH == 32 && size_eff == SIZE_DOUBLE) begin
      size_eff = SIZE_WORD;
    end
    n_bytes    = 4'd1 << size_eff;
    align_mask = LANE_W'(n_bytes - 4'd1);
    size_ones  = BYTES'((16'd1 << n_bytes) - 16'd1);
  end

  // The word index wraps modulo MEM_WORDS simply by truncation.
  assign offset     = alu_result_in - BASE;
  assign lane       = LANE_W'(offset);
  assign word_idx   = IDX_W'(offset >> LANE_W);

  assign access_req = mem_read_in | mem_write_in;
  assign misaligned = access_req & (|(lane & align_mask));
  assign access_ok  = access_req & ~misaligned;
  // A simultaneous read+write is treated as a pure store.
  assign is_load    = mem_read_in & ~mem_write_in;

  // ---------------------------------------------------------------------------
  // Data memory
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] store_shifted;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [BYTES-1:0]      byte_en;
  logic                  mem_we;

  assign rd_word       = mem_q[word_idx];
  assign store_shifted = store_data_in << {lane, 3'b000};
  assign byte_en       = size_ones << lane;

  // Read-modify-write merge: only the addressed lanes take the new bytes.
  always_comb begin
    merged_word = rd_word;
    for (int b = 0; b < BYTES; b++) begin
      if (byte_en[b]) begin
        merged_word[8*b +: 8] = store_shifted[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction and extension
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] load_shifted;
  logic [DATA_WIDTH-1:0] keep_mask;
  logic [DATA_WIDTH-1:0] load_ext;
  logic                  sign_bit;

  assign load_shifted = rd_word >> {lane, 3'b000};

  always_comb begin
    keep_mask = '1;
    sign_bit  = load_shifted[DATA_WIDTH-1];
    case (size_eff)
      SIZE_BYTE: begin
        keep_mask = DATA_WIDTH'(8'hFF);
        sign_bit  = load_shifted[7];
      end
      SIZE_HALF: begin
        keep_mask = DATA_WIDTH'(16'hFFFF);
        sign_bit  = load_shifted[15];
      end
      SIZE_WORD: begin
        keep_mask = DATA_WIDTH'(32'hFFFF_FFFF);
        sign_bit  = load_shifted[31];
      end
      default: begin
        keep_mask = '1;
        sign_bit  = load_shifted[DATA_WIDTH-1];
      end
    endcase
    load_ext = (load_shifted & keep_mask)
             | ({DATA_WIDTH{mem_signed_in & sign_bit}} & ~keep_mask);
  end

  // ---------------------------------------------------------------------------
  // Latency FSM
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             final_cycle;
  logic             stall;

  // final_cycle means "an aligned access presented now completes this cycle".
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    final_cycle = 1'b1;
    if (MEM_LATENCY > 1) begin
      case (state_q)
        IDLE: begin
          final_cycle = 1'b0;
          if (access_ok) begin
            state_d = BUSY;
            cnt_d   = CNT_START;
          end
        end
        BUSY: begin
          final_cycle = (cnt_q == '0);
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign stall  = access_ok & ~final_cycle;
  // A reset on the final cycle still abandons the store.
  assign mem_we = mem_write_in & access_ok & final_cycle & ~rst;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the data array is deliberately not reset; its contents survive rst
  // and only the store path writes it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[word_idx] <= merged_word;
    end
  end

  // ---------------------------------------------------------------------------
  // MEM/WB pipeline register
  // ---------------------------------------------------------------------------
  logic                      wb_enable_q, wb_enable_d;
  logic                      mem_read_q, mem_read_d;
  logic [DATA_WIDTH-1:0]     alu_result_q, alu_result_d;
  logic [REG_ADDR_WIDTH-1:0] dest_reg_q, dest_reg_d;
  logic [DATA_WIDTH-1:0]     memory_data_q, memory_data_d;
  logic                      misaligned_q, misaligned_d;

  // Stall cycles register a bubble: control bits drop, payload holds.
  always_comb begin
    wb_enable_d   = 1'b0;
    mem_read_d    = 1'b0;
    alu_result_d  = alu_result_q;
    dest_reg_d    = dest_reg_q;
    memory_data_d = memory_data_q;
    misaligned_d  = misaligned;
    if (!stall) begin
      wb_enable_d   = wb_enable_in & ~misaligned;
      mem_read_d    = is_load & ~misaligned;
      alu_result_d  = alu_result_in;
      dest_reg_d    = dest_reg_in;
      memory_data_d = load_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_enable_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      alu_result_q  <= '0;
      dest_reg_q    <= '0;
      memory_data_q <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      wb_enable_q   <= wb_enable_d;
      mem_read_q    <= mem_read_d;
      alu_result_q  <= alu_result_d;
      dest_reg_q    <= dest_reg_d;
      memory_data_q <= memory_data_d;
      misaligned_q  <= misaligned_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign stall_out       = stall;
  assign result_out      = mem_read_in ? load_ext : alu_result_in;
  assign mem_read_out    = mem_read_q;
  assign wb_enable_out   = wb_enable_q;
  assign alu_result_out  = alu_result_q;
  assign dest_reg_out    = dest_reg_q;
  assign memory_data_out = memory_data_q;
  assign misaligned_out  = misaligned_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//
// Three instances of mem_access_stage (MEM_LATENCY 1, 3 and 4) share clk/rst
// and have separate request/response signals. A byte-level model of each data
// memory predicts load values; the expected pipeline timing is derived from
// the latency of each instance.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int DW    = 32;
  localparam int RW    = 5;
  localparam int WORDS = 64;
  localparam int BASE  = 1024;
  localparam int NDUT  = 3;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic          wb;
    logic [1:0]    size;
    logic          sgn;
    logic [RW-1:0] dest;
    logic [DW-1:0] addr;
    logic [DW-1:0] sdata;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  req_t          req      [NDUT];
  logic          stall_o  [NDUT];
  logic [DW-1:0] result_o [NDUT];
  logic          mrd_o    [NDUT];
  logic          wbe_o    [NDUT];
  logic [DW-1:0] alu_o    [NDUT];
  logic [RW-1:0] dest_o   [NDUT];
  logic [DW-1:0] md_o     [NDUT];
  logic          mis_o    [NDUT];

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mem_access_stage #(
      .DATA_WIDTH    (DW),
      .REG_ADDR_WIDTH(RW),
      .MEM_WORDS     (WORDS),
      .MEM_LATENCY   ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
      .BASE_ADDR     (BASE)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .mem_read_in    (req[g].rd),
      .mem_write_in   (req[g].wr),
      .wb_enable_in   (req[g].wb),
      .mem_size_in    (req[g].size),
      .mem_signed_in  (req[g].sgn),
      .dest_reg_in    (req[g].dest),
      .alu_result_in  (req[g].addr),
      .store_data_in  (req[g].sdata),
      .stall_out      (stall_o[g]),
      .result_out     (result_o[g]),
      .mem_read_out   (mrd_o[g]),
      .wb_enable_out  (wbe_o[g]),
      .alu_result_out (alu_o[g]),
      .dest_reg_out   (dest_o[g]),
      .memory_data_out(md_o[g]),
      .misaligned_out (mis_o[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  logic [31:0]   model_mem [NDUT][WORDS];
  logic [DW-1:0] exp_alu   [NDUT];
  logic [RW-1:0] exp_dest  [NDUT];
  int            last_dut = -1;
  int            checks   = 0;
  int            errors   = 0;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
  endfunction

  function automatic int unsigned nbytes_of(input logic [1:0] s);
    return (s == 2'd3) ? 4 : (1 << s);
  endfunction

  function automatic int unsigned offset_of(input logic [31:0] a);
    int unsigned base_u = BASE;
    return a - base_u;
  endfunction

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (offset_of(a) / 4) % WORDS;
  endfunction

  function automatic int unsigned lane_of(input logic [31:0] a);
    return offset_of(a) % 4;
  endfunction

  function automatic bit is_mis(input req_t r);
    return (r.rd || r.wr) && ((lane_of(r.addr) % nbytes_of(r.size)) != 0);
  endfunction

  // Load value from plain arithmetic: shift, modulo the access span, then
  // subtract the span when signed and the top bit of the span is set.
  function automatic logic [31:0] model_load(input int d, input req_t r);
    longint unsigned w, span, v;
    w    = model_mem[d][idx_of(r.addr)];
    span = 64'd1 << (8 * nbytes_of(r.size));
    v    = (w >> (8 * lane_of(r.addr))) % span;
    if (r.sgn && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  function automatic void model_store(input int d, input req_t r);
    logic [31:0] w;
    int unsigned ln;
    w  = model_mem[d][idx_of(r.addr)];
    ln = lane_of(r.addr);
    for (int k = 0; k < int'(nbytes_of(r.size)); k++) begin
      w[8*(ln+k) +: 8] = r.sdata[8*k +: 8];
    end
    model_mem[d][idx_of(r.addr)] = w;
  endfunction

  function automatic req_t mk_req(input bit rd, input bit wr, input bit wb,
                                  input logic [1:0] sz, input bit sgn,
                                  input logic [31:0] addr, input logic [31:0] data);
    req_t r;
    r       = '0;
    r.rd    = rd;
    r.wr    = wr;
    r.wb    = wb;
    r.size  = sz;
    r.sgn   = sgn;
    r.dest  = RW'($urandom);
    r.addr  = addr;
    r.sdata = data;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int   k;
    k       = $urandom_range(0, 9);
    r       = '0;
    r.rd    = (k < 4) || (k == 8);
    r.wr    = (k >= 4 && k < 8) || (k == 8);
    r.wb    = 1'($urandom_range(0, 1));
    r.size  = 2'($urandom_range(0, 3));
    r.sgn   = 1'($urandom_range(0, 1));
    r.dest  = RW'($urandom);
    r.sdata = $urandom;
    if (k == 9) begin
      r.addr = $urandom;
    end else begin
      r.addr = 32'(BASE - 256 + $urandom_range(0, 2047));
      if ($urandom_range(0, 3) != 0) r.addr = r.addr & ~(nbytes_of(r.size) - 1);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // One instruction through instance d. Entered 1 time unit after a rising
  // edge; returns 1 time unit after the edge that ends its last cycle.
  // ---------------------------------------------------------------------------
  task automatic do_access(input int d, input req_t r, output int stalls,
                           output logic [31:0] md);
    int          lat;
    bit          mis, acc, ld;
    logic [31:0] ld_exp, res_exp;
    bit          exp_stall, exp_wbe, exp_mrd;
    if (last_dut != d) begin
      for (int e = 0; e < NDUT; e++) if (e != d) req[e] = '0;
      exp_alu[d]  = '0;
      exp_dest[d] = '0;
    end
    last_dut = d;
    acc    = r.rd || r.wr;
    mis    = is_mis(r);
    ld     = r.rd && !r.wr;
    lat    = (acc && !mis) ? lat_of(d) : 1;
    ld_exp = model_load(d, r);
    req[d] = r;
    stalls = 0;
    for (int c = 1; c <= lat; c++) begin
      #1;
      exp_stall = (c < lat);
      checks++;
      if (stall_o[d] !== exp_stall) begin
        errors++;
        $display("FAIL stall dut%0d cyc%0d addr=%h: got %b expected %b",
                 d, c, r.addr, stall_o[d], exp_stall);
      end
      if (stall_o[d] === 1'b1) stalls++;
      if (c == lat && !mis) begin
        res_exp = r.rd ? ld_exp : r.addr;
        checks++;
        if (result_o[d] !== res_exp) begin
          errors++;
          $display("FAIL result_fwd dut%0d addr=%h: got %h expected %h",
                   d, r.addr, result_o[d], res_exp);
        end
      end
      @(posedge clk);
      #1;
      if (c < lat) begin
        checks++;
        if (wbe_o[d] !== 1'b0 || mrd_o[d] !== 1'b0 || mis_o[d] !== 1'b0 ||
            alu_o[d] !== exp_alu[d] || dest_o[d] !== exp_dest[d]) begin
          errors++;
          $display("FAIL bubble dut%0d cyc%0d: got wb/rd/mis=%b%b%b alu=%h dest=%0d expected 000 alu=%h dest=%0d",
                   d, c, wbe_o[d], mrd_o[d], mis_o[d], alu_o[d], dest_o[d],
                   exp_alu[d], exp_dest[d]);
        end
      end else begin
        exp_wbe = mis ? 1'b0 : r.wb;
        exp_mrd = ld && !mis;
        checks++;
        if (wbe_o[d] !== exp_wbe || mrd_o[d] !== exp_mrd || mis_o[d] !== mis) begin
          errors++;
          $display("FAIL capture_flags dut%0d addr=%h: got wb/rd/mis=%b%b%b expected %b%b%b",
                   d, r.addr, wbe_o[d], mrd_o[d], mis_o[d], exp_wbe, exp_mrd, mis);
        end
        checks++;
        if (alu_o[d] !== r.addr || dest_o[d] !== r.dest) begin
          errors++;
          $display("FAIL capture_fields dut%0d: got alu=%h dest=%0d expected alu=%h dest=%0d",
                   d, alu_o[d], dest_o[d], r.addr, r.dest);
        end
        if (ld && !mis) begin
          checks++;
          if (md_o[d] !== ld_exp) begin
            errors++;
            $display("FAIL load_data dut%0d addr=%h size=%0d sgn=%b: got %h expected %h",
                     d, r.addr, r.size, r.sgn, md_o[d], ld_exp);
          end
        end
      end
    end
    if (acc && !mis && r.wr) model_store(d, r);
    exp_alu[d]  = r.addr;
    exp_dest[d] = r.dest;
    md = md_o[d];
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    for (int e = 0; e < NDUT; e++) req[e] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int e = 0; e < NDUT; e++) begin
      checks++;
      if ({wbe_o[e], mrd_o[e], mis_o[e]} !== 3'b000 || alu_o[e] !== '0 ||
          dest_o[e] !== '0 || md_o[e] !== '0) begin
        errors++;
        $display("FAIL reset_regs dut%0d: got wb/rd/mis=%b%b%b alu=%h dest=%0d md=%h expected all 0",
                 e, wbe_o[e], mrd_o[e], mis_o[e], alu_o[e], dest_o[e], md_o[e]);
      end
    end
    rst = 1'b0;
    #1;
    for (int e = 0; e < NDUT; e++) begin
      checks++;
      if (stall_o[e] !== 1'b0) begin
        errors++;
        $display("FAIL reset_stall dut%0d: got %b expected 0", e, stall_o[e]);
      end
    end
    @(posedge clk);
    #1;
    for (int e = 0; e < NDUT; e++) begin
      exp_alu[e]  = '0;
      exp_dest[e] = '0;
    end
    last_dut = -1;
  endtask

  task automatic test_init_memories();
    int          s;
    logic [31:0] md;
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < WORDS; i++) begin
        do_access(d, mk_req(0, 1, 0, 2'b10, 0, 32'(BASE + 4 * i), $urandom), s, md);
      end
    end
  endtask

  task automatic test_word_store_loads();
    int          s;
    logic [31:0] md;
    do_access(0, mk_req(0, 1, 0, 2'b10, 0, 32'd1024, 32'hDEADBEEF), s, md);
    do_access(0, mk_req(1, 0, 1, 2'b00, 1, 32'd1025, 32'h0), s, md);
    checks++;
    if (md !== 32'hFFFFFFBE) begin
      errors++;
      $display("FAIL lb_signed_1025: got %h expected FFFFFFBE", md);
    end
    do_access(0, mk_req(1, 0, 1, 2'b01, 1, 32'd1026, 32'h0), s, md);
    checks++;
    if (md !== 32'hFFFFDEAD) begin
      errors++;
      $display("FAIL lh_signed_1026: got %h expected FFFFDEAD", md);
    end
    do_access(0, mk_req(1, 0, 1, 2'b00, 0, 32'd1027, 32'h0), s, md);
    checks++;
    if (md !== 32'h000000DE) begin
      errors++;
      $display("FAIL lbu_1027: got %h expected 000000DE", md);
    end
  endtask

  task automatic test_byte_merge();
    int          s;
    logic [31:0] md;
    do_access(0, mk_req(0, 1, 0, 2'b00, 0, 32'd1025, 32'hCAFE0011), s, md);
    do_access(0, mk_req(1, 0, 1, 2'b10, 0, 32'd1024, 32'h0), s, md);
    checks++;
    if (md !== 32'hDEAD11EF) begin
      errors++;
      $display("FAIL byte_merge: got %h expected DEAD11EF", md);
    end
  endtask

  task automatic test_latency();
    int          s;
    logic [31:0] md;
    do_access(1, mk_req(1, 0, 1, 2'b10, 1, 32'd1024, 32'h0), s, md);
    checks++;
    if (s != 2) begin
      errors++;
      $display("FAIL lat3_stall_cycles: got %0d expected 2", s);
    end
    do_access(2, mk_req(0, 1, 1, 2'b01, 0, 32'd1030, 32'h0000A5A5), s, md);
    checks++;
    if (s != 3) begin
      errors++;
      $display("FAIL lat4_stall_cycles: got %0d expected 3", s);
    end
  endtask

  task automatic test_misaligned();
    int          s;
    logic [31:0] md;
    do_access(0, mk_req(0, 1, 1, 2'b10, 0, 32'd1026, 32'h12345678), s, md);
    do_access(0, mk_req(0, 0, 0, 2'b00, 0, 32'h0000_0042, 32'h0), s, md);
    do_access(0, mk_req(1, 0, 1, 2'b10, 0, 32'd1024, 32'h0), s, md);
    checks++;
    if (md !== 32'hDEAD11EF) begin
      errors++;
      $display("FAIL misaligned_no_write: got %h expected DEAD11EF", md);
    end
    do_access(1, mk_req(1, 0, 1, 2'b01, 1, 32'd1027, 32'h0), s, md);
    checks++;
    if (s != 0) begin
      errors++;
      $display("FAIL misaligned_no_stall: got %0d expected 0", s);
    end
  endtask

  task automatic test_wrap();
    int          s;
    logic [31:0] md;
    do_access(0, mk_req(0, 1, 0, 2'b10, 0, 32'd1280, 32'h5), s, md);
    do_access(0, mk_req(1, 0, 1, 2'b10, 0, 32'd1024, 32'h0), s, md);
    checks++;
    if (md !== 32'h5) begin
      errors++;
      $display("FAIL wrap_1280: got %h expected 00000005", md);
    end
  endtask

  task automatic test_reset_mid();
    int          s;
    logic [31:0] md, old;
    req_t        r;
    do_access(2, '0, s, md);
    old = model_mem[2][1];
    r   = mk_req(0, 1, 1, 2'b10, 0, 32'd1028, ~old);
    req[2] = r;
    #1;
    checks++;
    if (stall_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_stall: got %b expected 1", stall_o[2]);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int e = 0; e < NDUT; e++) begin
      checks++;
      if ({wbe_o[e], mrd_o[e], mis_o[e]} !== 3'b000 || alu_o[e] !== '0 ||
          dest_o[e] !== '0 || md_o[e] !== '0) begin
        errors++;
        $display("FAIL rst_mid_regs dut%0d: got wb/rd/mis=%b%b%b alu=%h dest=%0d md=%h expected all 0",
                 e, wbe_o[e], mrd_o[e], mis_o[e], alu_o[e], dest_o[e], md_o[e]);
      end
    end
    rst    = 1'b0;
    req[2] = '0;
    #1;
    checks++;
    if (stall_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_idle_stall: got %b expected 0", stall_o[2]);
    end
    @(posedge clk);
    #1;
    for (int e = 0; e < NDUT; e++) begin
      exp_alu[e]  = '0;
      exp_dest[e] = '0;
    end
    last_dut = -1;
    do_access(2, mk_req(1, 0, 1, 2'b10, 0, 32'd1028, 32'h0), s, md);
    checks++;
    if (md !== old) begin
      errors++;
      $display("FAIL rst_mid_not_committed: got %h expected %h", md, old);
    end
  endtask

  task automatic test_back_to_back();
    int          s;
    int unsigned start;
    logic [31:0] md;
    req_t        r;
    for (int d = 0; d < 2; d++) begin
      do_access(d, '0, s, md);
      start = cyc;
      for (int i = 0; i < 6; i++) begin
        r      = rand_req();
        r.rd   = 1'b1;
        r.wr   = 1'b0;
        r.wb   = 1'b1;
        r.addr = 32'(BASE + 4 * $urandom_range(0, WORDS - 1));
        do_access(d, r, s, md);
      end
      checks++;
      if (cyc - start != 6 * lat_of(d)) begin
        errors++;
        $display("FAIL back_to_back_cycles dut%0d: got %0d expected %0d",
                 d, cyc - start, 6 * lat_of(d));
      end
    end
  endtask

  task automatic test_random();
    int          s;
    logic [31:0] md;
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 60; i++) begin
        do_access(d, rand_req(), s, md);
      end
    end
  endtask

  initial begin
    for (int e = 0; e < NDUT; e++) req[e] = '0;
    test_reset();
    test_init_memories();
    test_word_store_loads();
    test_byte_merge();
    test_latency();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
